// File: rtl/cliffwalking_pkg.sv
// Shared constants for the CliffWalking step sequencer: FSM encoding,
// grid geometry, start cell and default widths.
package cliffwalking_pkg;

    // Grid is 12 columns by 4 rows, cell index = row*12 + col.
    localparam int GRID_COLS = 12;
    localparam int GRID_ROWS = 4;

    // Start cell is the bottom-left corner of the grid.
    localparam int INIT_STA_DEF = (GRID_ROWS - 1) * GRID_COLS;

    // Default widths and limits.
    localparam int PE_NUM_DEF    = 1;
    localparam int STA_WL_DEF    = 32;
    localparam int ACT_WL_DEF    = 2;
    localparam int OBS_WL_DEF    = 32;
    localparam int RWD_WL_DEF    = 1;
    localparam int MAX_STEPS_DEF = 100;
    localparam int TIMEOUT_DEF   = 16;

    // Step-sequencer FSM encoding.
    typedef logic [1:0] fsm_state_t;
    localparam fsm_state_t ST_IDLE  = 2'd0;
    localparam fsm_state_t ST_ISSUE = 2'd1;
    localparam fsm_state_t ST_WAIT  = 2'd2;
    localparam fsm_state_t ST_RESP  = 2'd3;

endpackage

// File: rtl/cliffwalking_pe_track.sv
// Per-environment tracker: holds one PE's state word and episode step
// counter, and decides between committing the Compute result and reloading
// the start cell on episode end or truncation.
module cliffwalking_pe_track
    import cliffwalking_pkg::*;
#(
    parameter int STA_WL    = STA_WL_DEF,
    parameter int INIT_STA  = INIT_STA_DEF,
    parameter int MAX_STEPS = MAX_STEPS_DEF,
    parameter int STEP_WL   = $clog2(MAX_STEPS + 1)
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic              i_load_init,
    input  logic              i_commit,
    input  logic [STA_WL-1:0] i_cmp_sta,
    input  logic              i_cmp_done,
    output logic [STA_WL-1:0] o_sta,
    output logic              o_trunc
);

    localparam logic [STA_WL-1:0]  INIT_VAL = STA_WL'(INIT_STA);
    localparam logic [STEP_WL:0]   MAX_CNT  = (STEP_WL + 1)'(MAX_STEPS);

    logic [STA_WL-1:0]  sta_q, sta_d;
    logic [STEP_WL-1:0] step_cnt_q, step_cnt_d;
    logic [STEP_WL:0]   cnt_inc;

    // Truncation: this step would be the last allowed one and did not end the episode.
    always_comb begin
        cnt_inc = {1'b0, step_cnt_q} + (STEP_WL + 1)'(1);
        o_trunc = (cnt_inc == MAX_CNT) && !i_cmp_done;
    end

    // Next state: reload on reset command / episode end, else take Compute's state.
    always_comb begin
        // NOTE: defaults first so every path assigns sta_d/step_cnt_d; no latch is inferred.
        sta_d      = sta_q;
        step_cnt_d = step_cnt_q;
        if (i_load_init) begin
            sta_d      = INIT_VAL;
            step_cnt_d = '0;
        end else if (i_commit) begin
            if (i_cmp_done || o_trunc) begin
                sta_d      = INIT_VAL;
                step_cnt_d = '0;
            end else begin
                sta_d      = i_cmp_sta;
                step_cnt_d = cnt_inc[STEP_WL-1:0];
            end
        end
    end

    // State and step-counter registers.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (!i_rstn) begin
            sta_q      <= INIT_VAL;
            step_cnt_q <= '0;
        end else begin
            sta_q      <= sta_d;
            step_cnt_q <= step_cnt_d;
        end
    end

    assign o_sta = sta_q;

endmodule

// File: rtl/cliffwalking_step_ctrl.sv
// Step sequencer between the host/agent and the CliffWalking Compute block:
// accepts action batches or environment-reset commands, fires one Compute
// step, applies episode-end/truncation rules and returns the results.
module cliffwalking_step_ctrl
    import cliffwalking_pkg::*;
#(
    parameter int PE_NUM    = PE_NUM_DEF,
    parameter int STA_WL    = STA_WL_DEF,
    parameter int ACT_WL    = ACT_WL_DEF,
    parameter int OBS_WL    = OBS_WL_DEF,
    parameter int RWD_WL    = RWD_WL_DEF,
    parameter int INIT_STA  = INIT_STA_DEF,
    parameter int MAX_STEPS = MAX_STEPS_DEF,
    parameter int TIMEOUT   = TIMEOUT_DEF
) (
    input  logic                     i_clk,
    input  logic                     i_rstn,
    input  logic                     i_act_valid,
    input  logic [PE_NUM*ACT_WL-1:0] i_act,
    input  logic                     i_reset_req,
    output logic                     o_act_ready,
    output logic                     o_res_valid,
    input  logic                     i_res_ready,
    output logic [PE_NUM*OBS_WL-1:0] o_obs,
    output logic [PE_NUM*RWD_WL-1:0] o_rwd,
    output logic [PE_NUM-1:0]        o_done,
    output logic [PE_NUM-1:0]        o_trunc,
    output logic                     o_cmp_ena,
    output logic [PE_NUM*STA_WL-1:0] o_cmp_sta,
    output logic [PE_NUM*ACT_WL-1:0] o_cmp_act,
    input  logic [PE_NUM*STA_WL-1:0] i_cmp_sta,
    input  logic [PE_NUM*OBS_WL-1:0] i_cmp_obs,
    input  logic [PE_NUM*RWD_WL-1:0] i_cmp_rwd,
    input  logic [PE_NUM-1:0]        i_cmp_done,
    input  logic                     i_cmp_valid,
    output logic                     o_err,
    output logic [31:0]              o_step_total
);

    localparam int STEP_WL = $clog2(MAX_STEPS + 1);
    localparam int TMO_WL  = $clog2(TIMEOUT + 1);
    localparam logic [TMO_WL-1:0] TMO_LAST = TMO_WL'(TIMEOUT - 1);

    fsm_state_t                state_q, state_d;
    logic [PE_NUM*ACT_WL-1:0]  act_q, act_d;
    logic [TMO_WL-1:0]         tmo_q, tmo_d;
    logic                      err_q, err_d;
    logic [31:0]               step_total_q, step_total_d;
    logic [PE_NUM*OBS_WL-1:0]  obs_q, obs_d;
    logic [PE_NUM*RWD_WL-1:0]  rwd_q, rwd_d;
    logic [PE_NUM-1:0]         done_q, done_d;
    logic [PE_NUM-1:0]         trunc_q, trunc_d;

    logic                      load_init;
    logic                      commit;
    logic [PE_NUM-1:0]         pe_trunc;

    // Per-PE environment state trackers.
    for (genvar p = 0; p < PE_NUM; p++) begin : g_pe
        cliffwalking_pe_track #(
            .STA_WL    (STA_WL),
            .INIT_STA  (INIT_STA),
            .MAX_STEPS (MAX_STEPS),
            .STEP_WL   (STEP_WL)
        ) u_pe_track (
            .i_clk       (i_clk),
            .i_rstn      (i_rstn),
            .i_load_init (load_init),
            .i_commit    (commit),
            .i_cmp_sta   (i_cmp_sta[p*STA_WL +: STA_WL]),
            .i_cmp_done  (i_cmp_done[p]),
            .o_sta       (o_cmp_sta[p*STA_WL +: STA_WL]),
            .o_trunc     (pe_trunc[p])
        );
    end

    // Sequencer FSM: command intake, Compute issue, result wait/timeout, result hold.
    always_comb begin
        state_d      = state_q;
        act_d        = act_q;
        tmo_d        = tmo_q;
        err_d        = err_q;
        step_total_d = step_total_q;
        obs_d        = obs_q;
        rwd_d        = rwd_q;
        done_d       = done_q;
        trunc_d      = trunc_q;
        load_init    = 1'b0;
        commit       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // A reset command wins over a simultaneous action, which stays pending.
                if (i_reset_req) begin
                    load_init = 1'b1;
                    obs_d     = {PE_NUM{OBS_WL'(INIT_STA)}};
                    rwd_d     = '0;
                    done_d    = '0;
                    trunc_d   = '0;
                    state_d   = ST_RESP;
                end else if (i_act_valid) begin
                    act_d   = i_act;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                tmo_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (i_cmp_valid) begin
                    commit       = 1'b1;
                    obs_d        = i_cmp_obs;
                    rwd_d        = i_cmp_rwd;
                    done_d       = i_cmp_done;
                    trunc_d      = pe_trunc;
                    step_total_d = step_total_q + 32'd1;
                    state_d      = ST_RESP;
                end else if (tmo_q == TMO_LAST) begin
                    // Compute never answered: flag it and drop the step without a result.
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    tmo_d = tmo_q + TMO_WL'(1);
                end
            end
            ST_RESP: begin
                if (i_res_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Sequencer and result registers.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q      <= ST_IDLE;
            act_q        <= '0;
            tmo_q        <= '0;
            err_q        <= 1'b0;
            step_total_q <= '0;
            obs_q        <= '0;
            rwd_q        <= '0;
            done_q       <= '0;
            trunc_q      <= '0;
        end else begin
            state_q      <= state_d;
            act_q        <= act_d;
            tmo_q        <= tmo_d;
            err_q        <= err_d;
            step_total_q <= step_total_d;
            obs_q        <= obs_d;
            rwd_q        <= rwd_d;
            done_q       <= done_d;
            trunc_q      <= trunc_d;
        end
    end

    assign o_act_ready  = (state_q == ST_IDLE);
    assign o_res_valid  = (state_q == ST_RESP);
    assign o_cmp_ena    = (state_q == ST_ISSUE);
    assign o_cmp_act    = act_q;
    assign o_err        = err_q;
    assign o_step_total = step_total_q;
    assign o_obs        = obs_q;
    assign o_rwd        = rwd_q;
    assign o_done       = done_q;
    assign o_trunc      = trunc_q;

endmodule

// File: tb/tb_cliffwalking_step_ctrl.sv
// Self-checking bench for cliffwalking_step_ctrl: a CliffWalking Compute
// model answers each enable, and an environment model tracks every PE's
// position and episode length to predict results and the next issued state.
module tb_cliffwalking_step_ctrl;

    localparam int PE_NUM    = 2;
    localparam int STA_WL    = 32;
    localparam int ACT_WL    = 2;
    localparam int OBS_WL    = 32;
    localparam int RWD_WL    = 1;
    localparam int INIT_STA  = 36;
    localparam int MAX_STEPS = 3;
    localparam int TIMEOUT   = 16;
    localparam int AW        = PE_NUM * ACT_WL;

    logic                     i_clk;
    logic                     i_rstn;
    logic                     i_act_valid;
    logic [AW-1:0]            i_act;
    logic                     i_reset_req;
    logic                     o_act_ready;
    logic                     o_res_valid;
    logic                     i_res_ready;
    logic [PE_NUM*OBS_WL-1:0] o_obs;
    logic [PE_NUM*RWD_WL-1:0] o_rwd;
    logic [PE_NUM-1:0]        o_done;
    logic [PE_NUM-1:0]        o_trunc;
    logic                     o_cmp_ena;
    logic [PE_NUM*STA_WL-1:0] o_cmp_sta;
    logic [AW-1:0]            o_cmp_act;
    logic [PE_NUM*STA_WL-1:0] i_cmp_sta;
    logic [PE_NUM*OBS_WL-1:0] i_cmp_obs;
    logic [PE_NUM*RWD_WL-1:0] i_cmp_rwd;
    logic [PE_NUM-1:0]        i_cmp_done;
    logic                     i_cmp_valid;
    logic                     o_err;
    logic [31:0]              o_step_total;

    cliffwalking_step_ctrl #(
        .PE_NUM    (PE_NUM),
        .STA_WL    (STA_WL),
        .ACT_WL    (ACT_WL),
        .OBS_WL    (OBS_WL),
        .RWD_WL    (RWD_WL),
        .INIT_STA  (INIT_STA),
        .MAX_STEPS (MAX_STEPS),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .i_clk        (i_clk),
        .i_rstn       (i_rstn),
        .i_act_valid  (i_act_valid),
        .i_act        (i_act),
        .i_reset_req  (i_reset_req),
        .o_act_ready  (o_act_ready),
        .o_res_valid  (o_res_valid),
        .i_res_ready  (i_res_ready),
        .o_obs        (o_obs),
        .o_rwd        (o_rwd),
        .o_done       (o_done),
        .o_trunc      (o_trunc),
        .o_cmp_ena    (o_cmp_ena),
        .o_cmp_sta    (o_cmp_sta),
        .o_cmp_act    (o_cmp_act),
        .i_cmp_sta    (i_cmp_sta),
        .i_cmp_obs    (i_cmp_obs),
        .i_cmp_rwd    (i_cmp_rwd),
        .i_cmp_done   (i_cmp_done),
        .i_cmp_valid  (i_cmp_valid),
        .o_err        (o_err),
        .o_step_total (o_step_total)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int errors = 0;
    int checks = 0;

    // Environment model: position and episode length per PE, plus step total.
    int          env_sta   [PE_NUM];
    int          env_steps [PE_NUM];
    logic [31:0] exp_total;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // CliffWalking move: clamp at the grid edges.
    function automatic int cw_next(input int sta, input int act);
        int row;
        int col;
        row = sta / 12;
        col = sta % 12;
        case (act)
            0: if (row > 0)  row = row - 1;
            1: if (col < 11) col = col + 1;
            2: if (row < 3)  row = row + 1;
            default: if (col > 0) col = col - 1;
        endcase
        return row * 12 + col;
    endfunction

    function automatic logic [PE_NUM*STA_WL-1:0] model_sta_vec();
        logic [PE_NUM*STA_WL-1:0] v;
        for (int p = 0; p < PE_NUM; p++) v[p*STA_WL +: STA_WL] = STA_WL'(env_sta[p]);
        return v;
    endfunction

    task automatic model_reset();
        for (int p = 0; p < PE_NUM; p++) begin
            env_sta[p]   = INIT_STA;
            env_steps[p] = 0;
        end
    endtask

    task automatic junk_cmp();
        i_cmp_sta  = {$urandom(), $urandom()};
        i_cmp_obs  = {$urandom(), $urandom()};
        i_cmp_rwd  = RWD_WL'($urandom());
        i_cmp_done = PE_NUM'($urandom());
    endtask

    // One full action step. Starts on a negedge with the DUT idle; Compute
    // answers 'lat' cycles after the enable; consumer stalls 'bp' cycles.
    task automatic do_step(input logic [AW-1:0] act, input int lat, input int bp, input bit spurious);
        logic [PE_NUM*STA_WL-1:0] exp_cmp_sta;
        logic [PE_NUM*STA_WL-1:0] nxt_sta;
        logic [PE_NUM*OBS_WL-1:0] exp_obs;
        logic [PE_NUM*RWD_WL-1:0] exp_rwd;
        logic [PE_NUM-1:0]        exp_done;
        logic [PE_NUM-1:0]        exp_trunc;
        exp_cmp_sta = model_sta_vec();
        for (int p = 0; p < PE_NUM; p++) begin
            int n;
            bit d;
            bit t;
            n = cw_next(env_sta[p], int'(act[p*ACT_WL +: ACT_WL]));
            d = (n >= 37);
            t = (env_steps[p] + 1 == MAX_STEPS) && !d;
            nxt_sta[p*STA_WL +: STA_WL] = STA_WL'(n);
            exp_obs[p*OBS_WL +: OBS_WL] = {8'(p + 1), 24'(n)};
            exp_rwd[p*RWD_WL +: RWD_WL] = RWD_WL'(n >= 37 && n <= 46);
            exp_done[p]  = d;
            exp_trunc[p] = t;
            if (d || t) begin
                env_sta[p]   = INIT_STA;
                env_steps[p] = 0;
            end else begin
                env_sta[p]   = n;
                env_steps[p] = env_steps[p] + 1;
            end
        end
        exp_total = exp_total + 32'd1;

        i_act_valid = 1'b1;
        i_act       = act;
        check("step_act_ready", o_act_ready, 1);
        @(negedge i_clk);
        i_act_valid = 1'b0;
        i_act       = AW'($urandom());
        check("step_cmp_ena", o_cmp_ena, 1);
        check("step_cmp_sta", o_cmp_sta, exp_cmp_sta);
        check("step_cmp_act", o_cmp_act, act);
        // A valid seen while issuing must be ignored.
        i_cmp_valid = spurious;
        junk_cmp();
        for (int i = 1; i < lat; i++) begin
            @(negedge i_clk);
            i_cmp_valid = 1'b0;
            check("wait_cmp_ena_low", o_cmp_ena, 0);
            check("wait_cmp_sta_stable", o_cmp_sta, exp_cmp_sta);
        end
        @(negedge i_clk);
        i_cmp_valid = 1'b1;
        i_cmp_sta   = nxt_sta;
        i_cmp_obs   = exp_obs;
        i_cmp_rwd   = exp_rwd;
        i_cmp_done  = exp_done;
        check("wait_no_result", o_res_valid, 0);
        @(negedge i_clk);
        i_cmp_valid = 1'b0;
        junk_cmp();
        check("res_valid", o_res_valid, 1);
        check("res_obs", o_obs, exp_obs);
        check("res_rwd", o_rwd, exp_rwd);
        check("res_done", o_done, exp_done);
        check("res_trunc", o_trunc, exp_trunc);
        check("res_step_total", o_step_total, exp_total);
        check("res_act_ready", o_act_ready, 0);
        for (int i = 0; i < bp; i++) begin
            @(negedge i_clk);
            check("bp_res_valid", o_res_valid, 1);
            check("bp_obs", o_obs, exp_obs);
            check("bp_trunc", o_trunc, exp_trunc);
            check("bp_act_ready", o_act_ready, 0);
        end
        i_res_ready = 1'b1;
        @(negedge i_clk);
        i_res_ready = 1'b0;
        check("post_res_valid", o_res_valid, 0);
        check("post_act_ready", o_act_ready, 1);
        check("post_cmp_sta", o_cmp_sta, model_sta_vec());
    endtask

    // Environment-reset command, optionally colliding with an action.
    task automatic do_reset_cmd(input bit with_act, input logic [AW-1:0] act);
        i_reset_req = 1'b1;
        i_act_valid = with_act;
        i_act       = act;
        check("rst_act_ready", o_act_ready, 1);
        model_reset();
        @(negedge i_clk);
        i_reset_req = 1'b0;
        check("rst_res_valid", o_res_valid, 1);
        check("rst_obs", o_obs, {32'd36, 32'd36});
        check("rst_rwd", o_rwd, 0);
        check("rst_done", o_done, 0);
        check("rst_trunc", o_trunc, 0);
        check("rst_step_total", o_step_total, exp_total);
        check("rst_cmp_ena", o_cmp_ena, 0);
        i_res_ready = 1'b1;
        @(negedge i_clk);
        i_res_ready = 1'b0;
        check("rst_post_res_valid", o_res_valid, 0);
        check("rst_post_act_ready", o_act_ready, 1);
        check("rst_post_cmp_sta", o_cmp_sta, {32'd36, 32'd36});
    endtask

    // Issue a step that Compute never answers.
    task automatic do_timeout(input logic [AW-1:0] act);
        logic [PE_NUM*STA_WL-1:0] held;
        held        = model_sta_vec();
        i_act_valid = 1'b1;
        i_act       = act;
        check("tmo_act_ready", o_act_ready, 1);
        @(negedge i_clk);
        i_act_valid = 1'b0;
        check("tmo_cmp_ena", o_cmp_ena, 1);
        for (int i = 0; i < TIMEOUT; i++) begin
            @(negedge i_clk);
            check("tmo_busy", o_act_ready, 0);
        end
        check("tmo_err_not_yet", o_err, 0);
        @(negedge i_clk);
        check("tmo_err", o_err, 1);
        check("tmo_idle", o_act_ready, 1);
        check("tmo_no_result", o_res_valid, 0);
        check("tmo_sta_held", o_cmp_sta, held);
        check("tmo_total_held", o_step_total, exp_total);
    endtask

    initial begin
        logic [AW-1:0] r_act;
        i_rstn      = 1'b0;
        i_act_valid = 1'b0;
        i_act       = '0;
        i_reset_req = 1'b0;
        i_res_ready = 1'b0;
        i_cmp_valid = 1'b0;
        junk_cmp();
        model_reset();
        exp_total = '0;

        repeat (3) @(negedge i_clk);
        check("rst_ready", o_act_ready, 1);
        check("rst_valid", o_res_valid, 0);
        check("rst_cmp_sta", o_cmp_sta, {32'd36, 32'd36});
        check("rst_err", o_err, 0);
        check("rst_total", o_step_total, 0);
        check("rst_ena", o_cmp_ena, 0);
        check("rst_obs_zero", o_obs, 0);
        check("rst_done_zero", o_done, 0);
        i_rstn = 1'b1;
        @(negedge i_clk);
        check("idle_ready", o_act_ready, 1);

        // PE0 up (36->24), PE1 right into the cliff (36->37, done).
        do_step({2'd1, 2'd0}, 1, 0, 1'b0);
        check("d1_done", o_done, 2'b10);
        check("d1_next_sta", o_cmp_sta, {32'd36, 32'd24});
        // Two more ups: PE0 reaches its third step and truncates.
        do_step({2'd0, 2'd0}, 2, 0, 1'b0);
        do_step({2'd0, 2'd0}, 1, 0, 1'b1);
        check("d3_trunc", o_trunc, 2'b01);
        check("d3_next_sta", o_cmp_sta, {32'd12, 32'd36});
        // Backpressure for five cycles.
        do_step({2'd2, 2'd1}, 3, 5, 1'b0);
        // Reset command collides with an action; action follows next idle cycle.
        do_reset_cmd(1'b1, {2'd1, 2'd0});
        do_step({2'd1, 2'd0}, 1, 0, 1'b0);
        check("coll_sta", o_cmp_sta, {32'd36, 32'd24});
        // Compute timeout, then a normal step; error stays set.
        do_timeout({2'd3, 2'd3});
        do_step({2'd3, 2'd2}, 2, 1, 1'b0);
        check("err_sticky", o_err, 1);

        for (int k = 0; k < 40; k++) begin
            r_act = AW'($urandom());
            if ($urandom_range(0, 7) == 0) begin
                do_reset_cmd(1'($urandom()), r_act);
            end else begin
                do_step(r_act, int'($urandom_range(1, 4)), int'($urandom_range(0, 3)),
                        1'($urandom()));
            end
        end

        // Asynchronous reset in the middle of a step abandons it.
        i_act_valid = 1'b1;
        i_act       = 4'b0101;
        @(negedge i_clk);
        i_act_valid = 1'b0;
        @(negedge i_clk);
        #2 i_rstn = 1'b0;
        #1;
        check("arst_ready", o_act_ready, 1);
        check("arst_valid", o_res_valid, 0);
        check("arst_err", o_err, 0);
        check("arst_total", o_step_total, 0);
        check("arst_sta", o_cmp_sta, {32'd36, 32'd36});
        @(negedge i_clk);
        i_rstn = 1'b1;
        model_reset();
        exp_total = '0;
        @(negedge i_clk);
        check("arst_no_result", o_res_valid, 0);
        do_step({2'd0, 2'd1}, 2, 0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
